// File: rtl/ex_stage_pkg.sv
// ============================================================================
// ex_stage_pkg : bus widths, stall encoding, opcodes and bus layouts for EX
// Rev 1.0
// ============================================================================
`default_nettype none

package ex_stage_pkg;

   localparam int ID_TO_EX_WD  = 147;
   localparam int EX_TO_MEM_WD = 208;
   localparam int EX_TO_ID_WD  = 39;
   localparam int STALL_BUS_WD = 6;
   localparam int DIV_ITERS    = 32;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_NOR  = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] st_data;
      logic [3:0]  md_op;
      logic        mem_en;
      logic        mem_we;
      logic [1:0]  mem_size;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
   } id_ex_t;

   typedef struct packed {
      logic        hi_we;
      logic [31:0] hi_wdata;
      logic        lo_we;
      logic [31:0] lo_wdata;
      logic        r_lo;
      logic [31:0] r_lo_data;
      logic        r_hi;
      logic [31:0] r_hi_data;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_mem_t;

   // Store data is copied into every lane so the byte enables alone pick the target.
   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_B:  return {4{data[7:0]}};
         SIZE_H:  return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
// ============================================================================
// div_iter : 32-step restoring divider, IDLE -> BUSY -> DONE, signed or unsigned
// Rev 1.0
// ============================================================================
`default_nettype none

module div_iter #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ack,
   input  logic        signed_en,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   localparam int CNT_WD = $clog2(DIV_ITERS + 1);
   localparam logic [CNT_WD-1:0] LAST_STEP = CNT_WD'(DIV_ITERS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [63:0]       r_shift;
   logic [31:0]       r_divisor;
   logic [31:0]       r_a_raw;
   logic [CNT_WD-1:0] r_cnt;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_div_zero;

   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [63:0] w_shl;
   logic [32:0] w_diff;
   logic [63:0] w_step;

   assign w_abs_a = (signed_en && a[31]) ? (~a + 32'd1) : a;
   assign w_abs_b = (signed_en && b[31]) ? (~b + 32'd1) : b;

   // One restoring step: shift in, trial-subtract, keep the difference when no borrow.
   assign w_shl  = {r_shift[62:0], 1'b0};
   assign w_diff = {1'b0, w_shl[63:32]} - {1'b0, r_divisor};
   assign w_step = w_diff[32] ? w_shl : {w_diff[31:0], w_shl[31:1], 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_BUSY;
         S_BUSY:  if (r_cnt == LAST_STEP) w_next = S_DONE;
         S_DONE:  if (ack) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift    <= '0;
         r_divisor  <= '0;
         r_a_raw    <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_shift    <= {32'd0, w_abs_a};
         r_divisor  <= w_abs_b;
         r_a_raw    <= a;
         r_cnt      <= '0;
         r_neg_q    <= signed_en & (a[31] ^ b[31]);
         r_neg_r    <= signed_en & a[31];
         r_div_zero <= (b == 32'd0);
      end else if (r_state == S_BUSY) begin
         r_shift <= w_step;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Divide-by-zero bypasses sign fix-up so LO is all ones and HI is the raw dividend.
   always_comb begin
      busy = (r_state == S_BUSY);
      done = (r_state == S_DONE);
      if (r_div_zero) begin
         quot = 32'hFFFF_FFFF;
         rem  = r_a_raw;
      end else begin
         quot = r_neg_q ? (~r_shift[31:0] + 32'd1)  : r_shift[31:0];
         rem  = r_neg_r ? (~r_shift[63:32] + 32'd1) : r_shift[63:32];
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : MIPS execute stage - ID/EX register, ALU, data SRAM request, HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_BUS_WD-1:0] stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   input  logic [31:0]             hi_rdata,
   input  logic [31:0]             lo_rdata,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);

   id_ex_t      r_ex;
   ex_mem_t     w_mem;
   logic [31:0] w_alu;
   logic [4:0]  w_sa;
   logic [1:0]  w_addr_lo;
   logic        w_misaligned;
   logic        w_store;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_div_start;
   logic        w_div_busy;
   logic        w_div_done;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_unused_stall;

   assign w_unused_stall = ^{stall[5:4], stall[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ex <= '0;
      else if (stall[2] == STOP && stall[3] == NO_STOP)
         r_ex <= '0;
      else if (stall[2] == NO_STOP)
         r_ex <= id_ex_t'(id_to_ex_bus);
   end

   assign w_sa = r_ex.src1[4:0];

   always_comb begin
      w_alu = '0;
      case (r_ex.alu_op)
         ALU_ADD:  w_alu = r_ex.src1 + r_ex.src2;
         ALU_SUB:  w_alu = r_ex.src1 - r_ex.src2;
         ALU_SLT:  w_alu = {31'd0, $signed(r_ex.src1) < $signed(r_ex.src2)};
         ALU_SLTU: w_alu = {31'd0, r_ex.src1 < r_ex.src2};
         ALU_AND:  w_alu = r_ex.src1 & r_ex.src2;
         ALU_OR:   w_alu = r_ex.src1 | r_ex.src2;
         ALU_XOR:  w_alu = r_ex.src1 ^ r_ex.src2;
         ALU_NOR:  w_alu = ~(r_ex.src1 | r_ex.src2);
         ALU_SLL:  w_alu = r_ex.src2 << w_sa;
         ALU_SRL:  w_alu = r_ex.src2 >> w_sa;
         ALU_SRA:  w_alu = $signed(r_ex.src2) >>> w_sa;
         ALU_LUI:  w_alu = {r_ex.src2[15:0], 16'd0};
         default:  w_alu = '0;
      endcase
   end

   assign w_addr_lo    = w_alu[1:0];
   assign w_misaligned = r_ex.mem_en & r_ex.mem_we &
                         (((r_ex.mem_size == SIZE_W) && (w_addr_lo != 2'd0)) ||
                          ((r_ex.mem_size == SIZE_H) && w_addr_lo[0]));
   assign w_store      = r_ex.mem_en & r_ex.mem_we & ~w_misaligned;

   always_comb begin
      data_sram_wen = 4'b0000;
      if (w_store) begin
         case (r_ex.mem_size)
            SIZE_B:  data_sram_wen = 4'b0001 << w_addr_lo;
            SIZE_H:  data_sram_wen = 4'b0011 << w_addr_lo;
            default: data_sram_wen = 4'b1111;
         endcase
      end
   end

   assign data_sram_en    = r_ex.mem_en & ~w_misaligned;
   assign data_sram_addr  = w_alu;
   assign data_sram_wdata = replicate_store(r_ex.mem_size, r_ex.st_data);

   assign w_prod_s = $signed({{32{r_ex.src1[31]}}, r_ex.src1}) * $signed({{32{r_ex.src2[31]}}, r_ex.src2});
   assign w_prod_u = {32'd0, r_ex.src1} * {32'd0, r_ex.src2};

   assign w_div_start = (r_ex.md_op == MD_DIV) || (r_ex.md_op == MD_DIVU);

   div_iter #(
      .DIV_ITERS (DIV_ITERS)
   ) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .start     (w_div_start),
      .ack       (stall[2] == NO_STOP),
      .signed_en (r_ex.md_op == MD_DIV),
      .a         (r_ex.src1),
      .b         (r_ex.src2),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quot      (w_quot),
      .rem       (w_rem)
   );

   // Asserted in the issue cycle (still IDLE) so the 33-cycle window starts immediately.
   assign stallreq_for_ex = (w_div_start & ~w_div_busy & ~w_div_done) | w_div_busy;

   always_comb begin
      w_mem              = '0;
      w_mem.pc           = r_ex.pc;
      w_mem.data_ram_en  = data_sram_en;
      w_mem.data_ram_wen = data_sram_wen;
      w_mem.sel_rf_res   = r_ex.sel_rf_res;
      w_mem.rf_we        = r_ex.rf_we;
      w_mem.rf_waddr     = r_ex.rf_waddr;
      w_mem.ex_result    = w_alu;
      case (r_ex.md_op)
         MD_MULT: begin
            w_mem.hi_we    = 1'b1;
            w_mem.lo_we    = 1'b1;
            w_mem.hi_wdata = w_prod_s[63:32];
            w_mem.lo_wdata = w_prod_s[31:0];
         end
         MD_MULTU: begin
            w_mem.hi_we    = 1'b1;
            w_mem.lo_we    = 1'b1;
            w_mem.hi_wdata = w_prod_u[63:32];
            w_mem.lo_wdata = w_prod_u[31:0];
         end
         MD_DIV, MD_DIVU: begin
            w_mem.hi_we    = w_div_done;
            w_mem.lo_we    = w_div_done;
            w_mem.hi_wdata = w_div_done ? w_rem  : 32'd0;
            w_mem.lo_wdata = w_div_done ? w_quot : 32'd0;
         end
         MD_MTHI: begin
            w_mem.hi_we    = 1'b1;
            w_mem.hi_wdata = r_ex.src1;
         end
         MD_MTLO: begin
            w_mem.lo_we    = 1'b1;
            w_mem.lo_wdata = r_ex.src1;
         end
         MD_MFHI: begin
            w_mem.r_hi      = 1'b1;
            w_mem.r_hi_data = hi_rdata;
         end
         MD_MFLO: begin
            w_mem.r_lo      = 1'b1;
            w_mem.r_lo_data = lo_rdata;
         end
         default: ;
      endcase
   end

   assign ex_to_mem_bus = w_mem;
   assign ex_to_id_bus  = {r_ex.mem_en & ~r_ex.mem_we, r_ex.rf_we, r_ex.rf_waddr, w_alu};

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : directed vectors for ex_stage with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;
   import ex_stage_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   stall;
   logic [146:0] id_to_ex_bus;
   logic [31:0]  hi_rdata;
   logic [31:0]  lo_rdata;
   logic [207:0] ex_to_mem_bus;
   logic [38:0]  ex_to_id_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         stallreq_for_ex;

   int checks = 0;
   int errors = 0;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_to_ex_bus),
      .hi_rdata        (hi_rdata),
      .lo_rdata        (lo_rdata),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_id_bus    (ex_to_id_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .stallreq_for_ex (stallreq_for_ex)
   );

   always #5 clk = ~clk;

   wire        o_hi_we     = ex_to_mem_bus[207];
   wire [31:0] o_hi_wdata  = ex_to_mem_bus[206:175];
   wire        o_lo_we     = ex_to_mem_bus[174];
   wire [31:0] o_lo_wdata  = ex_to_mem_bus[173:142];
   wire        o_r_lo      = ex_to_mem_bus[141];
   wire [31:0] o_r_lo_data = ex_to_mem_bus[140:109];
   wire        o_ram_en    = ex_to_mem_bus[43];
   wire [3:0]  o_ram_wen   = ex_to_mem_bus[42:39];
   wire [31:0] o_result    = ex_to_mem_bus[31:0];
   wire        o_is_load   = ex_to_id_bus[38];

   task automatic check(input string tag, input logic [207:0] got, input logic [207:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [146:0] ins(input logic [3:0] alu, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] st, input logic [3:0] md, input logic men,
                                        input logic mwe, input logic [1:0] sz);
      return {32'h0040_0100, alu, s1, s2, st, md, men, mwe, sz, men & ~mwe, 1'b1, 5'd8};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [146:0] i);
      id_to_ex_bus = i;
      stall        = 6'b000000;
      step();
   endtask

   task automatic run_div(input string tag, input logic [146:0] i, input logic [31:0] lo_e, input logic [31:0] hi_e);
      int n;
      issue(i);
      stall        = 6'b001111;
      id_to_ex_bus = '0;
      n = 0;
      while (stallreq_for_ex && n < 100) begin
         n++;
         step();
      end
      check({tag, "_stall_cycles"}, n, 33);
      check({tag, "_we"}, {o_hi_we, o_lo_we}, 2'b11);
      check({tag, "_lo"}, o_lo_wdata, lo_e);
      check({tag, "_hi"}, o_hi_wdata, hi_e);
   endtask

   initial begin
      rst          = 1'b1;
      stall        = 6'b000000;
      id_to_ex_bus = '0;
      hi_rdata     = 32'h1111_2222;
      lo_rdata     = 32'h3333_4444;
      step();
      step();
      check("reset_mem_bus", ex_to_mem_bus, 208'd0);
      check("reset_id_bus", ex_to_id_bus, 39'd0);
      check("reset_sram_en", data_sram_en, 1'b0);
      check("reset_stallreq", stallreq_for_ex, 1'b0);
      rst = 1'b0;

      // ALU
      issue(ins(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("add_wrap", o_result, 32'h8000_0000);
      check("add_no_hilo", {o_hi_we, o_lo_we}, 2'b00);
      issue(ins(ALU_SUB, 32'h5, 32'h7, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("sub", o_result, 32'hFFFF_FFFE);
      issue(ins(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("slt", o_result, 32'h1);
      issue(ins(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("sltu", o_result, 32'h0);
      issue(ins(ALU_SRA, 32'h4, 32'h8000_0000, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("sra", o_result, 32'hF800_0000);
      issue(ins(ALU_SLL, 32'h4, 32'h0000_00F1, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("sll", o_result, 32'h0000_0F10);
      issue(ins(ALU_LUI, 32'h0, 32'hABCD_1234, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("lui", o_result, 32'h1234_0000);
      issue(ins(ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("nor", o_result, 32'hF0F0_FF00);

      // Memory requests
      issue(ins(ALU_ADD, 32'h1000, 32'h3, 32'h0000_00AB, MD_NONE, 1'b1, 1'b1, SIZE_B));
      check("sb_addr", data_sram_addr, 32'h1003);
      check("sb_wen", data_sram_wen, 4'b1000);
      check("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
      check("sb_en", {data_sram_en, o_ram_en, o_ram_wen}, 6'b11_1000);
      issue(ins(ALU_ADD, 32'h1000, 32'h1, 32'h0000_BEEF, MD_NONE, 1'b1, 1'b1, SIZE_H));
      check("sh_misaligned", {data_sram_en, data_sram_wen, o_ram_en, o_ram_wen}, 10'd0);
      issue(ins(ALU_ADD, 32'h1000, 32'h2, 32'h0000_BEEF, MD_NONE, 1'b1, 1'b1, SIZE_H));
      check("sh_upper", {data_sram_en, data_sram_wen, data_sram_wdata}, {1'b1, 4'b1100, 32'hBEEF_BEEF});
      issue(ins(ALU_ADD, 32'h1000, 32'h4, 32'h1234_5678, MD_NONE, 1'b1, 1'b1, SIZE_W));
      check("sw", {data_sram_en, data_sram_wen, data_sram_wdata}, {1'b1, 4'b1111, 32'h1234_5678});
      issue(ins(ALU_ADD, 32'h2000, 32'h4, 32'h0, MD_NONE, 1'b1, 1'b0, SIZE_W));
      check("lw", {data_sram_en, data_sram_wen, o_is_load}, 6'b1_0000_1);

      // HI/LO
      issue(ins(ALU_ADD, 32'hFFFF_FFFE, 32'h3, 32'h0, MD_MULT, 1'b0, 1'b0, SIZE_W));
      check("mult", {o_hi_we, o_hi_wdata, o_lo_we, o_lo_wdata}, {1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFA});
      issue(ins(ALU_ADD, 32'hFFFF_FFFE, 32'h3, 32'h0, MD_MULTU, 1'b0, 1'b0, SIZE_W));
      check("multu", {o_hi_we, o_hi_wdata, o_lo_we, o_lo_wdata}, {1'b1, 32'h0000_0002, 1'b1, 32'hFFFF_FFFA});
      issue(ins(ALU_ADD, 32'hDEAD_BEEF, 32'h0, 32'h0, MD_MTHI, 1'b0, 1'b0, SIZE_W));
      check("mthi", {o_hi_we, o_hi_wdata, o_lo_we}, {1'b1, 32'hDEAD_BEEF, 1'b0});
      issue(ins(ALU_ADD, 32'h0, 32'h0, 32'h0, MD_MFLO, 1'b0, 1'b0, SIZE_W));
      check("mflo", {o_r_lo, o_r_lo_data, o_hi_we, o_lo_we}, {1'b1, 32'h3333_4444, 2'b00});

      // Hold and bubble
      issue(ins(ALU_ADD, 32'h5, 32'h6, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      id_to_ex_bus = ins(ALU_ADD, 32'h50, 32'h60, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W);
      stall = 6'b001111;
      step();
      check("hold", o_result, 32'd11);
      stall = 6'b000111;
      step();
      check("bubble", ex_to_mem_bus, 208'd0);

      // Divider
      run_div("div_neg", ins(ALU_ADD, 32'hFFFF_FFF9, 32'h2, 32'h0, MD_DIV, 1'b0, 1'b0, SIZE_W),
              32'hFFFF_FFFD, 32'hFFFF_FFFF);
      for (int k = 0; k < 5; k++) begin
         step();
         check("done_hold_stallreq", stallreq_for_ex, 1'b0);
         check("done_hold_result", {o_lo_we, o_lo_wdata, o_hi_wdata}, {1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
      end
      issue(ins(ALU_ADD, 32'h1, 32'h1, 32'h0, MD_NONE, 1'b0, 1'b0, SIZE_W));
      check("after_div_idle", {stallreq_for_ex, o_hi_we, o_lo_we}, 3'b000);
      run_div("divu_zero", ins(ALU_ADD, 32'h7, 32'h0, 32'h0, MD_DIVU, 1'b0, 1'b0, SIZE_W),
              32'hFFFF_FFFF, 32'h7);

      // Asynchronous reset in the middle of a division
      issue(ins(ALU_ADD, 32'd1000, 32'd3, 32'h0, MD_DIVU, 1'b0, 1'b0, SIZE_W));
      stall = 6'b001111;
      id_to_ex_bus = '0;
      repeat (10) step();
      check("busy_before_rst", stallreq_for_ex, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_bus", ex_to_mem_bus, 208'd0);
      check("rst_mid_stallreq", stallreq_for_ex, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      stall = 6'b000000;
      step();
      check("rst_mid_idle", stallreq_for_ex, 1'b0);
      run_div("divu_100_7", ins(ALU_ADD, 32'd100, 32'd7, 32'h0, MD_DIVU, 1'b0, 1'b0, SIZE_W),
              32'd14, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
